// File: rtl/demux4l_6_buf_pkg.sv
// Shared constants and route-code type for the buffered 1-to-4 6-bit demux.
// Optional delivery counters are enabled with DEMUX4L_6_CNT_EN.
package demux_pkg;

  localparam int DATA_W = 6;
  localparam int NSLOT  = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [SEL_W-1:0] {
    SEL_00 = 2'b00,
    SEL_01 = 2'b01,
    SEL_10 = 2'b10,
    SEL_11 = 2'b11
  } sel_t;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/demux4l_6_buf_if.sv
// Producer/consumer bus of the buffered demux: one routed input channel and
// four independently handshaked output slots.
interface demux4l_6_buf_if;
  import demux_pkg::*;

  logic [SEL_W-1:0]  control;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out00;
  logic [DATA_W-1:0] out01;
  logic [DATA_W-1:0] out10;
  logic [DATA_W-1:0] out11;
  logic [NSLOT-1:0]  out_valid;
  logic [NSLOT-1:0]  out_ready;
  logic              busy;

  modport master (
    output control, in_data, in_valid, out_ready,
    input  in_ready, out00, out01, out10, out11, out_valid, busy
  );

  modport slave (
    input  control, in_data, in_valid, out_ready,
    output in_ready, out00, out01, out10, out11, out_valid, busy
  );

endinterface

// File: rtl/demux4l_6_buf_slot.sv
// One-entry output slot: load wins over drain so a slot can be refilled in
// the same cycle it is emptied. Counter present only with DEMUX4L_6_CNT_EN.
module demux_slot_6
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
`ifdef DEMUX4L_6_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt
`endif
);

  logic drain;

  assign drain = valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

`ifdef DEMUX4L_6_CNT_EN
  // Wraps naturally at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (drain) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/demux4l_6_buf.sv
// Buffered 1-to-4 demultiplexer for 6-bit fields. Build with DEMUX4L_6_CNT_EN
// to add the packed per-slot delivery counters on deliv_cnt.
module demux4l_6_buf
  import demux_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset,
  demux4l_6_buf_if.slave   bus
`ifdef DEMUX4L_6_CNT_EN
  ,
  output logic [31:0]      deliv_cnt
`endif
);

  logic              accept;
  logic [NSLOT-1:0]  load;
  logic [NSLOT-1:0]  valid;
  data_t             data [NSLOT];
`ifdef DEMUX4L_6_CNT_EN
  logic [CNT_W-1:0]  cnt [NSLOT];
`endif

  // The selected slot can take a word if it is empty or emptying this cycle.
  assign bus.in_ready = ~valid[bus.control] | bus.out_ready[bus.control];
  assign accept       = bus.in_valid & bus.in_ready;

  genvar i;
  generate
    for (i = 0; i < NSLOT; i++) begin : g_slot
      assign load[i] = accept & (bus.control == SEL_W'(i));

      demux_slot_6 u_slot (
        .clk       (CLK),
        .rst       (Reset),
        .load      (load[i]),
        .ready     (bus.out_ready[i]),
        .load_data (bus.in_data),
        .valid     (valid[i]),
        .data      (data[i])
`ifdef DEMUX4L_6_CNT_EN
        ,
        .cnt       (cnt[i])
`endif
      );
    end
  endgenerate

  assign bus.out_valid = valid;
  assign bus.busy      = |valid;
  assign bus.out00     = data[0];
  assign bus.out01     = data[1];
  assign bus.out10     = data[2];
  assign bus.out11     = data[3];

`ifdef DEMUX4L_6_CNT_EN
  assign deliv_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_demux4l_6_buf.sv
// Scoreboard bench for demux4l_6_buf: the driver queues expected words per
// slot on acceptance and a negedge monitor checks every delivered word.
module tb_demux4l_6_buf;
  import demux_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [5:0] q [NSLOT][$];
`ifdef DEMUX4L_6_CNT_EN
  logic [31:0] deliv_cnt;
`endif

  demux4l_6_buf_if bus ();

  demux4l_6_buf dut (
    .CLK       (clk),
    .Reset     (rst),
    .bus       (bus.slave)
`ifdef DEMUX4L_6_CNT_EN
    ,
    .deliv_cnt (deliv_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] slot_data(input int i);
    case (i)
      0:       return bus.out00;
      1:       return bus.out01;
      2:       return bus.out10;
      default: return bus.out11;
    endcase
  endfunction

  // Monitor: every delivered word must match the head of its slot's queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (bus.out_valid[i] && bus.out_ready[i]) begin
          if (q[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL deliver_unexpected slot%0d: got %0d expected none", i, slot_data(i));
          end else begin
            chk($sformatf("deliver_slot%0d", i), int'(slot_data(i)), int'(q[i].pop_front()));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    for (int i = 0; i < NSLOT; i++) q[i].delete();
  endtask

  // Offer one word; bounded wait on in_ready, queue it when the edge accepts it.
  task automatic send(input int ch, input logic [5:0] d);
    bit done;
    done = 0;
    bus.control  = 2'(ch);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q[ch].push_back(d);
        done = 1;
      end
      tick();
    end
    if (!done) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_q();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.control   = 2'b00;
    bus.in_data   = 6'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_out00", int'(bus.out00), 0);
    chk("rst_out11", int'(bus.out11), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    tick();

    // Basic routing to slot 2
    bus.control  = 2'b10;
    bus.in_data  = 6'h2A;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("route_in_ready", int'(bus.in_ready), 1);
    q[2].push_back(6'h2A);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("route_out_valid", int'(bus.out_valid), 4'b0100);
    chk("route_out10", int'(bus.out10), 6'h2A);
    chk("route_busy", int'(bus.busy), 1);
    tick();

    // Reset mid-operation with a handshake pending for slot 1
    send(0, 6'h07);
    bus.control  = 2'b01;
    bus.in_data  = 6'h15;
    bus.in_valid = 1'b1;
    do_reset();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out00", int'(bus.out00), 0);
    chk("mid_rst_out01", int'(bus.out01), 0);
    chk("mid_rst_out10", int'(bus.out10), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    tick();

    // Backpressure on slot 3
    send(3, 6'h11);
    bus.control  = 2'b11;
    bus.in_data  = 6'h3F;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", int'(bus.in_ready), 0);
      chk("bp_out11_hold", int'(bus.out11), 6'h11);
      tick();
    end
    bus.out_ready = 4'b1000;
    @(negedge clk);
    chk("bp_in_ready_high", int'(bus.in_ready), 1);
    q[3].push_back(6'h3F);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    @(negedge clk);
    chk("bp_out11_new", int'(bus.out11), 6'h3F);
    chk("bp_valid3", int'(bus.out_valid[3]), 1);
    tick();
    bus.out_ready = 4'b1000;
    tick();
    bus.out_ready = 4'b0000;
    @(negedge clk);
    chk("bp_drained", int'(bus.out_valid), 0);
    chk("bp_out11_kept", int'(bus.out11), 6'h3F);
    tick();

    // Streaming 1..4 into slot 0 with the consumer always ready
    bus.out_ready = 4'b0001;
    bus.control   = 2'b00;
    bus.in_valid  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.in_data = 6'(k);
      @(negedge clk);
      chk("stream_in_ready", int'(bus.in_ready), 1);
      if (k > 1) chk("stream_no_bubble", int'(bus.out00), k - 1);
      q[0].push_back(6'(k));
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 4'b0000;
    @(negedge clk);
    chk("stream_empty", int'(bus.out_valid), 0);
    tick();

    // Concurrent accept into slot 0 with drains of slots 1 and 3
    send(1, 6'h09);
    send(3, 6'h0C);
    bus.out_ready = 4'b1010;
    bus.control   = 2'b00;
    bus.in_data   = 6'h05;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    chk("conc_in_ready", int'(bus.in_ready), 1);
    q[0].push_back(6'h05);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    @(negedge clk);
    chk("conc_out_valid", int'(bus.out_valid), 4'b0001);
    chk("conc_out00", int'(bus.out00), 6'h05);
    tick();
    // out_ready on empty slots 1..3 must not disturb anything
    bus.out_ready = 4'b1110;
    tick();
    bus.out_ready = 4'b0000;
    @(negedge clk);
    chk("idle_ready_noop", int'(bus.out_valid), 4'b0001);
    tick();
    bus.out_ready = 4'b0001;
    tick();
    bus.out_ready = 4'b0000;

`ifdef DEMUX4L_6_CNT_EN
    // 257 drains of slot 2 wrap its counter to 1
    do_reset();
    bus.out_ready = 4'b0100;
    bus.control   = 2'b10;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 257; k++) begin
      bus.in_data = 6'(k);
      @(negedge clk);
      if (bus.in_ready) q[2].push_back(6'(k));
      else chk("cnt_in_ready", 0, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 4'b0000;
    @(negedge clk);
    chk("cnt_value", int'(deliv_cnt), 32'h0001_0000);
    tick();
`endif

    for (int i = 0; i < NSLOT; i++)
      chk($sformatf("queue_empty_slot%0d", i), q[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/demux4l_6_buf.md
Name: demux4l_6_buf

Overview:
- 1-to-4 buffered demultiplexer for 6-bit fields. It is the write-side counterpart of the 4-way 6-bit selector used in the multi-cycle CPU datapath.
- One producer channel carries data plus a 2-bit route code. Each word is steered into one of four one-entry output slots.
- Each slot has its own valid/ready handshake. Consumers (e.g. per-stage field latches) drain their slots independently.
- Sits between the control unit's field producer and the four datapath consumers.

Parameters:
- none (data width 6 and fan-out 4 are fixed; the constants live in the package)

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset, sampled on the rising edge of CLK
- control  in  2  route code for in_data: 00→slot 0, 01→slot 1, 10→slot 2, 11→slot 3; must be stable while in_valid=1
- in_data  in  6  data word to route
- in_valid  in  1  producer presents control/in_data
- in_ready  out  1  selected slot can accept this cycle (combinational)
- out00, out01, out10, out11  out  6 each  data held in slots 0..3
- out_valid  out  4  bit i = slot i holds an undelivered word
- out_ready  in  4  bit i = consumer i takes slot i's word this cycle
- busy  out  1  OR of out_valid

Behaviour:
- Reset (Reset=1 at a rising edge):
  - out_valid=0000, all outNN=6'd0, busy=0.
  - Counters (if built) are cleared to 0.
  - Any buffered words are discarded; a handshake in the same cycle is ignored.
- Definitions:
  - full[i] = out_valid[i]
  - drain[i] = full[i] & out_ready[i]
  - s = control
- in_ready = ~full[s] | out_ready[s]. It is combinational from control and out_ready and is independent of in_valid.
- accept = in_valid & in_ready. On accept, slot s loads in_data and full[s] is set to 1.
- Drain without refill: full[i] clears to 0. outNN keeps its last value; it is not zeroed.
- Drain and refill of the same slot in one cycle: full stays 1 and the data is replaced. This sustains one word per cycle to a single slot.
- Latency: a word accepted at edge k appears on outNN with out_valid=1 immediately after edge k. The consumer can take it at edge k+1.
- Slot independence: slots that are neither selected nor draining hold data and valid unchanged. Any number of slots may drain in the same cycle as an accept to another slot.
- Full, undrained selected slot: in_ready=0 and nothing changes. The producer must hold control, in_data and in_valid until in_ready=1.
- out_ready[i] while out_valid[i]=0 has no effect.
- No reordering: each slot holds at most one word, so per-slot order is trivially preserved.

Optional Feature:
- Macro: DEMUX4L_6_CNT_EN
- Defined:
  - Adds output port deliv_cnt (32 bits) = four 8-bit counters {cnt3,cnt2,cnt1,cnt0}.
  - cnt_i increments on every drain[i] and wraps 255→0.
  - Counters are cleared by Reset.
- Undefined: the port and the counters do not exist; all other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - DATA_W=6, NSLOT=4
  - route code constants SEL_00..SEL_11
  - CNT_W=8
- One natural sub-module, demux_slot_6: a one-entry buffer with load/drain inputs and valid/data outputs (plus an optional counter). It is instantiated four times.
- The top level holds the route decode, the in_ready mux and busy.

Test Plan:
- Reset mid-operation:
  - Stimulus: load slots 0 and 2, then assert Reset with in_valid=1, control=01 in the same cycle.
  - Required: after the edge, out_valid=0000, out00..out11=0, busy=0, and slot 1 is not loaded.
- Basic routing:
  - Stimulus: control=10, in_data=6'h2A, in_valid=1, out_ready=0000.
  - Required: in_ready=1; next cycle out_valid=0100, out10=6'h2A, busy=1.
- Backpressure:
  - Stimulus: slot 3 full (6'h11), out_ready[3]=0, send control=11 with in_data=6'h3F.
  - Required: in_ready=0 for 3 cycles, out11 stays 6'h11. Then raising out_ready[3] gives in_ready=1, and next cycle out11=6'h3F with out_valid[3]=1.
- Streaming into one slot:
  - Stimulus: out_ready[0]=1, control=00, in_data 1,2,3,4 on consecutive cycles.
  - Required: in_ready held at 1; the consumer sees 1,2,3,4 on consecutive cycles with no bubble.
- Concurrent accept and drains:
  - Stimulus: slots 1 and 3 full, out_ready=1010, accept control=00 in_data=6'h05.
  - Required: next cycle out_valid=0001, out00=6'h05.
- Counter (DEMUX4L_6_CNT_EN defined):
  - Stimulus: 257 drains of slot 2.
  - Required: deliv_cnt[23:16]=1, all other counter bytes 0.
